logic_op_issue: RTL and testbench

- Buffered issue stage that sits directly upstream of the 8-bit logic engine and owns its operands.
- Accepts {opcode, A, B} operations over a valid/ready handshake and queues them in a small FIFO.
- Evaluates one operation per cycle using the engine's opcode map and holds each result in a registered output slot with valid/ready backpressure.
- Keeps a completed-operation counter for software and debug.

---
 rtl/logic_op_issue_if.sv | 60 ++++++
 rtl/logic_op_issue.sv | 135 +++++++++++++
 tb/tb_logic_op_issue.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_op_issue_if.sv
// Handshake/bus bundle for the logic_op_issue stage; the out_zero flag is present
// only when LOGIC_OP_ZFLAG_EN is defined.
interface logic_op_issue_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic [1:0]       in_opcode;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_result;
    logic [1:0]       out_opcode;
    logic [LVL_W-1:0] level;
    logic [CNT_W-1:0] op_count;
`ifdef LOGIC_OP_ZFLAG_EN
    logic             out_zero;
`endif

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_opcode,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_opcode,
        input  level,
        input  op_count
`ifdef LOGIC_OP_ZFLAG_EN
        , input out_zero
`endif
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_opcode,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result,
        output out_opcode,
        output level,
        output op_count
`ifdef LOGIC_OP_ZFLAG_EN
        , output out_zero
`endif
    );
endinterface

// File: rtl/logic_op_issue.sv
// Buffered issue stage for the 8-bit logic engine: input FIFO, one-op-per-cycle
// evaluation into a registered output slot, and a completion counter. Optional zero flag under LOGIC_OP_ZFLAG_EN.
module logic_op_issue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             rst,
    logic_op_issue_if.slave io_bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } entry_t;

    function automatic logic [7:0] f_eval(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] res;
        case (op)
            2'b00:   res = a | b;
            2'b01:   res = ~(a & b);
            2'b10:   res = ~(a | b);
            2'b11:   res = a & b;
            default: res = 8'h00;
        endcase
        return res;
    endfunction

    entry_t           r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             r_out_valid;
    logic [7:0]       r_out_result;
    logic [1:0]       r_out_opcode;
    logic [CNT_W-1:0] r_op_count;
`ifdef LOGIC_OP_ZFLAG_EN
    logic             r_out_zero;
`endif

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_hs;
    entry_t           w_head;
    logic [7:0]       w_result;

    // Handshake qualifiers; flush masks every state-changing event of its cycle.
    always_comb begin
        w_full   = (r_level == LW'(DEPTH));
        w_empty  = (r_level == LW'(0));
        w_push   = io_bus.in_valid && !w_full && !io_bus.flush;
        w_pop    = !w_empty && (!r_out_valid || io_bus.out_ready) && !io_bus.flush;
        w_hs     = r_out_valid && io_bus.out_ready && !io_bus.flush;
        w_head   = r_mem[r_rptr];
        w_result = f_eval(w_head.op, w_head.a, w_head.b);
    end

    // FIFO storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{op: io_bus.in_opcode, a: io_bus.in_a, b: io_bus.in_b};
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst || io_bus.flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Output slot: a load wins over a drain so throughput stays at one op per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_result <= 8'h00;
            r_out_opcode <= 2'b00;
`ifdef LOGIC_OP_ZFLAG_EN
            r_out_zero   <= 1'b0;
`endif
        end else if (io_bus.flush) begin
            r_out_valid  <= 1'b0;
`ifdef LOGIC_OP_ZFLAG_EN
            r_out_zero   <= 1'b0;
`endif
        end else if (w_pop) begin
            r_out_valid  <= 1'b1;
            r_out_result <= w_result;
            r_out_opcode <= w_head.op;
`ifdef LOGIC_OP_ZFLAG_EN
            r_out_zero   <= (w_result == 8'h00);
`endif
        end else if (w_hs) begin
            r_out_valid  <= 1'b0;
        end
    end

    // Completed-handshake counter; survives flush, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (w_hs) begin
            r_op_count <= r_op_count + CNT_W'(1);
        end
    end

    assign io_bus.in_ready   = !w_full;
    assign io_bus.out_valid  = r_out_valid;
    assign io_bus.out_result = r_out_result;
    assign io_bus.out_opcode = r_out_opcode;
    assign io_bus.level      = r_level;
    assign io_bus.op_count   = r_op_count;
`ifdef LOGIC_OP_ZFLAG_EN
    assign io_bus.out_zero   = r_out_zero;
`endif
endmodule

// File: tb/tb_logic_op_issue.sv
// Directed bench for logic_op_issue (DEPTH=4, CNT_W=4) with a result scoreboard;
// zero-flag checks are active when LOGIC_OP_ZFLAG_EN is defined.
module tb_logic_op_issue;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic_op_issue_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    logic_op_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus.slave)
    );

    int              n_pass  = 0;
    int              n_total = 0;
    logic [10:0]     sb_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;
    logic            last_acc;

    function automatic logic [7:0] ref_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return a | b;
            2'b01:   return ~(a & b);
            2'b10:   return ~(a | b);
            default: return a & b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic put(input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid  = v;
        bus.in_opcode = op;
        bus.in_a      = a;
        bus.in_b      = b;
    endtask

    // One clock: observe handshakes at the negedge, score them, then step past the edge.
    task automatic cyc();
        logic [10:0] e;
        logic [7:0]  r;
        @(negedge clk);
        last_acc = bus.in_valid && bus.in_ready && !bus.flush && !rst;
        if (rst || bus.flush) begin
            sb_q.delete();
            if (rst) exp_cnt = '0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_result", bus.out_result, e[7:0]);
                    chk("sb_opcode", bus.out_opcode, e[9:8]);
`ifdef LOGIC_OP_ZFLAG_EN
                    chk("sb_zero", bus.out_zero, e[10]);
`endif
                end
                exp_cnt = exp_cnt + 1'b1;
            end
            if (last_acc) begin
                r = ref_op(bus.in_opcode, bus.in_a, bus.in_b);
                sb_q.push_back({(r == 8'h00), bus.in_opcode, r});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (sb_q.size() != 0 && n < max_cyc) begin
            cyc();
            n++;
        end
        chk("drain_empty", sb_q.size(), 0);
        chk("drain_out_valid", bus.out_valid, 1'b0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_level"},     bus.level,      0);
        chk({tag, "_in_ready"},  bus.in_ready,   1);
        chk({tag, "_out_valid"}, bus.out_valid,  0);
        chk({tag, "_result"},    bus.out_result, 8'h00);
        chk({tag, "_opcode"},    bus.out_opcode, 2'b00);
        chk({tag, "_op_count"},  bus.op_count,   0);
`ifdef LOGIC_OP_ZFLAG_EN
        chk({tag, "_zero"},      bus.out_zero,   1'b0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        put(1'b0, 2'b00, 8'h00, 8'h00);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset("reset");

        // Single op: visible after the second edge
        bus.out_ready = 1'b1;
        put(1'b1, 2'b00, 8'hF0, 8'h0F);
        cyc();
        put(1'b0, 2'b00, 8'h00, 8'h00);
        chk("single_lat_valid", bus.out_valid, 1'b0);
        chk("single_lat_level", bus.level, 1);
        cyc();
        chk("single_valid", bus.out_valid, 1'b1);
        chk("single_result", bus.out_result, 8'hFF);
        chk("single_opcode", bus.out_opcode, 2'b00);
        cyc();
        chk("single_count", bus.op_count, 1);
        chk("single_drained", bus.out_valid, 1'b0);

        // Opcode sweep back-to-back
        for (int i = 0; i < 4; i++) begin
            put(1'b1, 2'(i), 8'hCC, 8'hAA);
            cyc();
        end
        put(1'b0, 2'b00, 8'h00, 8'h00);
        chk("sweep_mid_result", bus.out_result, 8'h11);
        chk("sweep_mid_valid", bus.out_valid, 1'b1);
        repeat (2) cyc();
        chk("sweep_count", bus.op_count, 5);
        chk("sweep_idle", bus.out_valid, 1'b0);
        chk("sweep_level", bus.level, 0);

        // Backpressure until full, sixth op stalls
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            put(1'b1, 2'(k), 8'((k + 1) * 17), 8'h5A);
            cyc();
        end
        put(1'b1, 2'b01, 8'h66, 8'h5A);
        repeat (3) cyc();
        chk("full_level", bus.level, 4);
        chk("full_in_ready", bus.in_ready, 1'b0);
        chk("full_hold_valid", bus.out_valid, 1'b1);
        chk("full_hold_result", bus.out_result, 8'h5B);
        chk("full_hold_opcode", bus.out_opcode, 2'b00);
        chk("full_sixth_stalled", sb_q.size(), 5);
        bus.out_ready = 1'b1;
        cyc();
        chk("full_no_bypass", last_acc, 1'b0);
        chk("full_release_ready", bus.in_ready, 1'b1);
        chk("full_release_level", bus.level, 3);
        cyc();
        chk("full_sixth_taken", last_acc, 1'b1);
        put(1'b0, 2'b00, 8'h00, 8'h00);
        drain(20);
        chk("full_count", bus.op_count, 11);

        // Flush with a same-cycle push and handshake
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            put(1'b1, 2'(k), 8'h3C, 8'(k));
            cyc();
        end
        chk("flush_pre_level", bus.level, 3);
        chk("flush_pre_valid", bus.out_valid, 1'b1);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        put(1'b1, 2'b11, 8'hFF, 8'hFF);
        cyc();
        bus.flush = 1'b0;
        put(1'b0, 2'b00, 8'h00, 8'h00);
        chk("flush_level", bus.level, 0);
        chk("flush_valid", bus.out_valid, 1'b0);
        chk("flush_count", bus.op_count, 11);
        chk("flush_in_ready", bus.in_ready, 1'b1);
        cyc();
        chk("flush_not_stored_valid", bus.out_valid, 1'b0);
        chk("flush_not_stored_level", bus.level, 0);

        // Reset mid-stream drops queued work
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            put(1'b1, 2'b10, 8'(k), 8'h81);
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        put(1'b0, 2'b00, 8'h00, 8'h00);
        chk_reset("midrst");

        // Counter wrap at CNT_W=4
        bus.out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            put(1'b1, 2'(k), 8'(k * 13), 8'hC3);
            cyc();
        end
        put(1'b0, 2'b00, 8'h00, 8'h00);
        drain(10);
        chk("wrap_count", bus.op_count, 1);
        chk("wrap_model", bus.op_count, exp_cnt);

        // Zero result under backpressure
        bus.out_ready = 1'b0;
        put(1'b1, 2'b11, 8'h0F, 8'hF0);
        cyc();
        put(1'b1, 2'b00, 8'h0F, 8'hF0);
        cyc();
        put(1'b0, 2'b00, 8'h00, 8'h00);
        cyc();
        chk("zero_result", bus.out_result, 8'h00);
        chk("zero_opcode", bus.out_opcode, 2'b11);
`ifdef LOGIC_OP_ZFLAG_EN
        chk("zero_flag_set", bus.out_zero, 1'b1);
        cyc();
        chk("zero_flag_hold", bus.out_zero, 1'b1);
`endif
        bus.out_ready = 1'b1;
        cyc();
        chk("zero_next_result", bus.out_result, 8'hFF);
`ifdef LOGIC_OP_ZFLAG_EN
        chk("zero_flag_clear", bus.out_zero, 1'b0);
`endif
        drain(10);
        chk("final_count", bus.op_count, exp_cnt);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
